core_io_peripheral: RTL and testbench

Peripheral-side endpoint of a core's peripheral port. It captures the result words the core pushes out on its to-peripheral channel, which are writes to s1 and s2–s9 (x9, x18–x25). Captured words go into a FIFO that a host or testbench drains. In the other direction it delivers host-issued command/data words to the core as single-cycle pulses on the from-peripheral channel. One instance sits beside each core in single- and multi-core top levels.

---
 rtl/core_io_peripheral.sv | 223 ++++++++++++++++++++++
 tb/tb_core_io_peripheral.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_io_peripheral.sv
// core_io_peripheral
// Peripheral-side endpoint of a core's peripheral port.
//   Receive path: every to_peripheral_valid strobe pushes {tag, data} into a
//   small FIFO that the host drains with host_rd_en. There is no backpressure
//   toward the core. A push into a full FIFO is dropped unless a pop happens in
//   the same cycle. Drops set a sticky overflow flag and bump a saturating
//   counter.
//   Transmit path: the host hands over {tag, data} through a valid/ready
//   handshake. The block replays it to the core as a one-cycle
//   from_peripheral_valid pulse, then enforces an idle gap.
// Ports:
//   clock, reset            : single clock, synchronous active-high reset
//   to_peripheral*          : result channel from the core (tag, data, strobe)
//   from_peripheral*        : command channel to the core (tag, data, strobe)
//   host_rd_en/_data/_valid : FIFO pop request and registered pop result
//   host_count              : FIFO occupancy
//   host_cmd_*              : host command handshake (ready is state-decoded)
//   overflow, drop_count    : sticky drop flag and saturating drop counter
//   clear_overflow          : clears overflow and drop_count
module core_io_peripheral #(
  parameter int          CORE            = 0,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_BITS = 3,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 to_peripheral,
  input  logic [DATA_WIDTH-1:0]      to_peripheral_data,
  input  logic                       to_peripheral_valid,
  output logic [1:0]                 from_peripheral,
  output logic [DATA_WIDTH-1:0]      from_peripheral_data,
  output logic                       from_peripheral_valid,
  input  logic                       host_rd_en,
  output logic [DATA_WIDTH+1:0]      host_rd_data,
  output logic                       host_rd_valid,
  output logic [FIFO_DEPTH_BITS:0]   host_count,
  input  logic                       host_cmd_valid,
  output logic                       host_cmd_ready,
  input  logic [1:0]                 host_cmd_tag,
  input  logic [DATA_WIDTH-1:0]      host_cmd_data,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  input  logic                       clear_overflow
);

  localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
  localparam int unsigned CNT_W   = FIFO_DEPTH_BITS + 1;
  localparam int unsigned PTR_W   = FIFO_DEPTH_BITS;
  // Wide enough to hold GAP_CYCLES-1.
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // ---------------------------------------------------------------------------
  // Receive path: core -> FIFO -> host
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ENTRY_W-1:0] r_rd_data;
  logic               r_rd_valid;
  logic               r_overflow;
  logic [15:0]        r_drop_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CNT_W'(DEPTH));
    w_pop   = host_rd_en && !w_empty;
    w_push  = to_peripheral_valid && (!w_full || w_pop);
    w_drop  = to_peripheral_valid && w_full && !w_pop;
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {to_peripheral, to_peripheral_data};
    end
  end

  // Pointers, occupancy and pop result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop tracking; a clear wins over a drop in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation trace of every accepted capture.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      $display("core%0d peripheral capture: tag=%0d data=0x%h",
               CORE, to_peripheral, to_peripheral_data);
    end
  end
`endif

  assign host_rd_data  = r_rd_data;
  assign host_rd_valid = r_rd_valid;
  assign host_count    = r_count;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

  // ---------------------------------------------------------------------------
  // Transmit path: host -> core, FSM IDLE -> SEND -> GAP -> IDLE
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_fp_valid;
  logic [1:0]           r_fp_tag;
  logic [DATA_WIDTH-1:0] r_fp_data;

  logic w_cmd_ready;
  logic w_accept;
  logic w_gap_load;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (host_cmd_valid) w_state_next = ST_SEND;
      ST_SEND: w_state_next = ST_GAP;
      ST_GAP:  if (r_gap_cnt == '0) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_gap_load  = 1'b0;
    case (r_state)
      ST_IDLE: w_cmd_ready = 1'b1;
      ST_SEND: w_gap_load  = 1'b1;
      default: ;
    endcase
    w_accept = w_cmd_ready && host_cmd_valid;
  end

  // Output registers double as the command latch; the strobe lines up with SEND.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fp_valid <= 1'b0;
      r_fp_tag   <= '0;
      r_fp_data  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_fp_valid <= w_accept;
      if (w_accept) begin
        r_fp_tag  <= host_cmd_tag;
        r_fp_data <= host_cmd_data;
      end
      if (w_gap_load) begin
        r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  assign host_cmd_ready        = w_cmd_ready;
  assign from_peripheral_valid = r_fp_valid;
  assign from_peripheral       = r_fp_tag;
  assign from_peripheral_data  = r_fp_data;

endmodule

// File: tb/tb_core_io_peripheral.sv
// Directed bench for core_io_peripheral with default parameters
// (32-bit data, 8-entry FIFO, GAP_CYCLES=2).
module tb_core_io_peripheral;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  to_peripheral;
  logic [31:0] to_peripheral_data;
  logic        to_peripheral_valid;
  logic [1:0]  from_peripheral;
  logic [31:0] from_peripheral_data;
  logic        from_peripheral_valid;
  logic        host_rd_en;
  logic [33:0] host_rd_data;
  logic        host_rd_valid;
  logic [3:0]  host_count;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic [1:0]  host_cmd_tag;
  logic [31:0] host_cmd_data;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_overflow;

  int total = 0;
  int bad   = 0;

  core_io_peripheral dut (
    .clock                 (clock),
    .reset                 (reset),
    .to_peripheral         (to_peripheral),
    .to_peripheral_data    (to_peripheral_data),
    .to_peripheral_valid   (to_peripheral_valid),
    .from_peripheral       (from_peripheral),
    .from_peripheral_data  (from_peripheral_data),
    .from_peripheral_valid (from_peripheral_valid),
    .host_rd_en            (host_rd_en),
    .host_rd_data          (host_rd_data),
    .host_rd_valid         (host_rd_valid),
    .host_count            (host_count),
    .host_cmd_valid        (host_cmd_valid),
    .host_cmd_ready        (host_cmd_ready),
    .host_cmd_tag          (host_cmd_tag),
    .host_cmd_data         (host_cmd_data),
    .overflow              (overflow),
    .drop_count            (drop_count),
    .clear_overflow        (clear_overflow)
  );

  always #5 clock = ~clock;

  // Advance one clock; sampling and driving happen 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    to_peripheral_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      to_peripheral      = 2'(i % 4);
      to_peripheral_data = base + 32'(i);
      tick();
    end
    to_peripheral_valid = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    to_peripheral       = '0;
    to_peripheral_data  = '0;
    to_peripheral_valid = 1'b0;
    host_rd_en          = 1'b0;
    host_cmd_valid      = 1'b0;
    host_cmd_tag        = '0;
    host_cmd_data       = '0;
    clear_overflow      = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count",    64'(host_count), 64'd0);
    chk("rst_rd_valid", 64'(host_rd_valid), 64'd0);
    chk("rst_rd_data",  64'(host_rd_data), 64'd0);
    chk("rst_ready",    64'(host_cmd_ready), 64'd1);
    chk("rst_fp_valid", 64'(from_peripheral_valid), 64'd0);
    chk("rst_fp_data",  64'(from_peripheral_data), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drops",    64'(drop_count), 64'd0);

    // 1: three captures, three back-to-back pops
    to_peripheral_valid = 1'b1;
    to_peripheral = 2'd0;
    to_peripheral_data = 32'h11;
    tick();
    chk("t1_count_after_first", 64'(host_count), 64'd1);
    to_peripheral_data = 32'h22;
    tick();
    to_peripheral_data = 32'h33;
    tick();
    to_peripheral_valid = 1'b0;
    chk("t1_count3", 64'(host_count), 64'd3);
    host_rd_en = 1'b1;
    tick();
    chk("t1_pop0_valid", 64'(host_rd_valid), 64'd1);
    chk("t1_pop0_data",  64'(host_rd_data), 64'h0_0000_0011);
    tick();
    chk("t1_pop1_data",  64'(host_rd_data), 64'h0_0000_0022);
    tick();
    chk("t1_pop2_data",  64'(host_rd_data), 64'h0_0000_0033);
    chk("t1_count0",     64'(host_count), 64'd0);
    host_rd_en = 1'b0;

    // 2: ten captures into an eight-entry FIFO
    push_n(10, 32'h100);
    chk("t2_count8",    64'(host_count), 64'd8);
    chk("t2_overflow",  64'(overflow), 64'd1);
    chk("t2_drops2",    64'(drop_count), 64'd2);
    host_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_pop%0d", i), 64'(host_rd_data), {30'd0, 2'(i % 4), 32'h100 + 32'(i)});
    end
    host_rd_en = 1'b0;
    chk("t2_count0", 64'(host_count), 64'd0);

    // 3: push and pop together while full
    push_n(8, 32'h200);
    to_peripheral_valid = 1'b1;
    to_peripheral = 2'd3;
    to_peripheral_data = 32'h2FF;
    host_rd_en = 1'b1;
    tick();
    to_peripheral_valid = 1'b0;
    chk("t3_count_full",  64'(host_count), 64'd8);
    chk("t3_no_new_drop", 64'(drop_count), 64'd2);
    chk("t3_head",        64'(host_rd_data), 64'h0_0000_0200);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t3_pop%0d", i), 64'(host_rd_data), {30'd0, 2'(i % 4), 32'h200 + 32'(i)});
    end
    tick();
    chk("t3_last_new", 64'(host_rd_data), 64'h3_0000_02FF);
    tick();
    chk("t3_empty_pop_valid", 64'(host_rd_valid), 64'd0);
    chk("t3_empty_pop_hold",  64'(host_rd_data), 64'h3_0000_02FF);
    host_rd_en = 1'b0;

    // 4: held command; pulses one cycle after each handshake, four cycles apart
    host_cmd_valid = 1'b1;
    host_cmd_tag   = 2'd1;
    host_cmd_data  = 32'hDEADBEEF;
    tick();
    chk("t4_pulse1",      64'(from_peripheral_valid), 64'd1);
    chk("t4_pulse1_tag",  64'(from_peripheral), 64'd1);
    chk("t4_pulse1_data", 64'(from_peripheral_data), 64'hDEADBEEF);
    chk("t4_ready_send",  64'(host_cmd_ready), 64'd0);
    host_cmd_tag  = 2'd2;
    host_cmd_data = 32'h12345678;
    tick();
    chk("t4_gap1_valid", 64'(from_peripheral_valid), 64'd0);
    chk("t4_gap1_ready", 64'(host_cmd_ready), 64'd0);
    tick();
    chk("t4_gap2_valid", 64'(from_peripheral_valid), 64'd0);
    chk("t4_hold_data",  64'(from_peripheral_data), 64'hDEADBEEF);
    tick();
    chk("t4_idle_valid", 64'(from_peripheral_valid), 64'd0);
    chk("t4_idle_ready", 64'(host_cmd_ready), 64'd1);
    tick();
    host_cmd_valid = 1'b0;
    chk("t4_pulse2",      64'(from_peripheral_valid), 64'd1);
    chk("t4_pulse2_tag",  64'(from_peripheral), 64'd2);
    chk("t4_pulse2_data", 64'(from_peripheral_data), 64'h12345678);
    tick();
    chk("t4_single_cycle", 64'(from_peripheral_valid), 64'd0);
    tick();
    tick();
    chk("t4_ready_again", 64'(host_cmd_ready), 64'd1);

    // 5: reset during GAP with five entries queued
    push_n(5, 32'h500);
    chk("t5_count5", 64'(host_count), 64'd5);
    host_cmd_valid = 1'b1;
    host_cmd_tag   = 2'd3;
    host_cmd_data  = 32'hCAFEF00D;
    tick();
    host_cmd_valid = 1'b0;
    tick();
    chk("t5_in_gap", 64'(host_cmd_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_count",    64'(host_count), 64'd0);
    chk("t5_ready",    64'(host_cmd_ready), 64'd1);
    chk("t5_fp_valid", 64'(from_peripheral_valid), 64'd0);
    chk("t5_fp_tag",   64'(from_peripheral), 64'd0);
    chk("t5_fp_data",  64'(from_peripheral_data), 64'd0);
    chk("t5_rd_data",  64'(host_rd_data), 64'd0);
    chk("t5_rd_valid", 64'(host_rd_valid), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    chk("t5_drops",    64'(drop_count), 64'd0);

    // 6: clear beats a same-cycle drop, then counter saturation
    push_n(8, 32'h600);
    to_peripheral_valid = 1'b1;
    to_peripheral_data  = 32'h6FF;
    tick();
    chk("t6_first_drop", 64'(drop_count), 64'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("t6_clear_overflow", 64'(overflow), 64'd0);
    chk("t6_clear_drops",    64'(drop_count), 64'd0);
    chk("t6_count_full",     64'(host_count), 64'd8);
    repeat (70000) tick();
    to_peripheral_valid = 1'b0;
    chk("t6_saturated", 64'(drop_count), 64'hFFFF);
    chk("t6_overflow",  64'(overflow), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
